// File: rtl/rob_mp_pkg.sv
// Shared defaults and helpers for the multi-port reorder buffer.
package rob_mp_pkg;

  localparam int ROB_AW     = 5;
  localparam int ROB_PAY_W  = 38;
  localparam int ROB_DATA_W = 32;
  localparam int ROB_DISP_W = 4;
  localparam int ROB_RET_W  = 2;
  localparam int ROB_WB_P   = 4;
  localparam int ROB_RD_P   = 8;

  // A tag is the entry index plus one wrap bit, so full and empty can be told apart.
  function automatic int tag_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/rob_ret_sel.sv
// Contiguous retire scan: lane i may retire only if every entry from head to head+i
// is valid and done and lies inside the retire window.
module rob_ret_sel #(
  parameter int RET_W = 2,
  parameter int TAG_W = 6,
  parameter int ADV_W = 2
) (
  input  logic [TAG_W-1:0] cnt,
  input  logic [RET_W-1:0] vd,
  output logic [RET_W-1:0] ret_v,
  output logic [ADV_W-1:0] adv
);

  logic run;

  // Walk lanes in order; the first lane that is not ready stops the run.
  always_comb begin
    run   = 1'b1;
    adv   = {ADV_W{1'b0}};
    ret_v = {RET_W{1'b0}};
    for (int i = 0; i < RET_W; i++) begin
      run      = run & vd[i] & (TAG_W'(i) < cnt);
      ret_v[i] = run;
      if (run) begin
        adv = adv + ADV_W'(1'b1);
      end else begin
        adv = adv;
      end
    end
  end

endmodule

// File: rtl/rob_mp.sv
// Multi-port reorder buffer: in-order allocate, out-of-order writeback,
// in-order retire, precise squash of everything younger than a branch.
module rob_mp
  import rob_mp_pkg::*;
#(
  parameter int AW     = ROB_AW,
  parameter int PAY_W  = ROB_PAY_W,
  parameter int DATA_W = ROB_DATA_W,
  parameter int DISP_W = ROB_DISP_W,
  parameter int RET_W  = ROB_RET_W,
  parameter int WB_P   = ROB_WB_P,
  parameter int RD_P   = ROB_RD_P
) (
  input  logic                          wclk,
  input  logic                          rst,
  input  logic [$clog2(DISP_W+1)-1:0]   disp_cnt,
  input  logic [DISP_W*PAY_W-1:0]       disp_pay,
  output logic                          disp_ok,
  output logic [DISP_W*(AW+1)-1:0]      disp_tag,
  input  logic [WB_P-1:0]               wb_v,
  input  logic [WB_P*(AW+1)-1:0]        wb_tag,
  input  logic [WB_P*DATA_W-1:0]        wb_data,
  input  logic [RD_P*(AW+1)-1:0]        rd_tag,
  output logic [RD_P*DATA_W-1:0]        rd_data,
  output logic [RD_P-1:0]               rd_done,
  output logic [RET_W-1:0]              ret_v,
  output logic [RET_W*PAY_W-1:0]        ret_pay,
  output logic [RET_W*DATA_W-1:0]       ret_data,
  input  logic                          ret_rdy,
  input  logic                          flush_v,
  input  logic [AW:0]                   flush_tag,
  output logic [AW:0]                   count,
  output logic                          empty,
  output logic                          full
);

  localparam int TAG_W = tag_width(AW);
  localparam int DEPTH = 1 << AW;
  localparam int CW    = $clog2(DISP_W + 1);
  localparam int ADV_W = $clog2(RET_W + 1);

  logic [TAG_W-1:0]  head_r, tail_r;
  logic [DEPTH-1:0]  valid_r, done_r;
  logic [PAY_W-1:0]  pay_r  [DEPTH];
  logic [DATA_W-1:0] data_r [DEPTH];

  logic [TAG_W-1:0]  count_s, free_s, flush_off_s, ret_cnt_s;
  logic              flush_live_s, disp_fire_s;
  logic [RET_W-1:0]  vd_s;
  logic [ADV_W-1:0]  adv_s;
  logic [AW-1:0]     ret_idx_s  [RET_W];
  logic [AW-1:0]     disp_idx_s [DISP_W];
  logic [DISP_W-1:0] disp_lane_s;
  logic [AW-1:0]     wb_idx_s   [WB_P];
  logic [WB_P-1:0]   wb_ok_s;
  logic [DEPTH-1:0]  squash_s;

  // Occupancy and window arithmetic are all modulo 2**TAG_W, so wrap is free.
  assign count_s      = tail_r - head_r;
  assign free_s       = TAG_W'(DEPTH) - count_s;
  assign flush_off_s  = flush_tag - head_r;
  assign flush_live_s = flush_v && (flush_off_s < count_s);
  assign disp_ok      = !flush_live_s && (free_s >= TAG_W'(disp_cnt));
  assign disp_fire_s  = disp_ok && (disp_cnt != CW'(1'b0));

  assign count = count_s;
  assign empty = (head_r == tail_r);
  assign full  = (head_r[AW-1:0] == tail_r[AW-1:0]) && (head_r[AW] != tail_r[AW]);

  // While a branch squashes, nothing beyond it may retire in the same cycle.
  assign ret_cnt_s = flush_live_s ? (flush_off_s + TAG_W'(1'b1)) : count_s;

  for (genvar i = 0; i < RET_W; i++) begin : g_ret
    logic [TAG_W-1:0] t_s;
    assign t_s          = head_r + TAG_W'(i);
    assign ret_idx_s[i] = t_s[AW-1:0];
    assign vd_s[i]      = valid_r[ret_idx_s[i]] & done_r[ret_idx_s[i]];
    assign ret_pay[i*PAY_W +: PAY_W]    = pay_r[ret_idx_s[i]];
    assign ret_data[i*DATA_W +: DATA_W] = data_r[ret_idx_s[i]];
  end

  rob_ret_sel #(.RET_W(RET_W), .TAG_W(TAG_W), .ADV_W(ADV_W)) u_ret_sel (
    .cnt   (ret_cnt_s),
    .vd    (vd_s),
    .ret_v (ret_v),
    .adv   (adv_s)
  );

  for (genvar i = 0; i < DISP_W; i++) begin : g_disp
    logic [TAG_W-1:0] t_s;
    assign t_s                          = tail_r + TAG_W'(i);
    assign disp_tag[i*TAG_W +: TAG_W]   = t_s;
    assign disp_idx_s[i]                = t_s[AW-1:0];
    assign disp_lane_s[i]               = disp_fire_s && (CW'(i) < disp_cnt);
  end

  // A writeback lands only on a live, valid entry that this cycle's squash keeps.
  for (genvar p = 0; p < WB_P; p++) begin : g_wb
    logic [TAG_W-1:0] off_s;
    assign off_s       = wb_tag[p*TAG_W +: TAG_W] - head_r;
    assign wb_idx_s[p] = wb_tag[p*TAG_W +: AW];
    assign wb_ok_s[p]  = wb_v[p] && (off_s < count_s) && valid_r[wb_idx_s[p]]
                         && !(flush_live_s && (off_s > flush_off_s));
  end

  for (genvar r = 0; r < RD_P; r++) begin : g_rd
    logic [TAG_W-1:0] off_s;
    logic [AW-1:0]    idx_s;
    logic             live_s;
    assign off_s  = rd_tag[r*TAG_W +: TAG_W] - head_r;
    assign idx_s  = rd_tag[r*TAG_W +: AW];
    assign live_s = (off_s < count_s) && valid_r[idx_s];
    assign rd_data[r*DATA_W +: DATA_W] = live_s ? data_r[idx_s] : {DATA_W{1'b0}};
    assign rd_done[r] = live_s & done_r[idx_s];
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_sq
    logic [AW-1:0] eo_s;
    assign eo_s        = AW'(e) - head_r[AW-1:0];
    assign squash_s[e] = flush_live_s && ({1'b0, eo_s} > flush_off_s) && ({1'b0, eo_s} < count_s);
  end

  // Entry and pointer update; later assignments deliberately override earlier ones
  // (higher writeback port beats lower, retire clear beats a writeback to the same slot).
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      head_r  <= {TAG_W{1'b0}};
      tail_r  <= {TAG_W{1'b0}};
      valid_r <= {DEPTH{1'b0}};
      done_r  <= {DEPTH{1'b0}};
      for (int e = 0; e < DEPTH; e++) begin
        pay_r[e]  <= {PAY_W{1'b0}};
        data_r[e] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int p = 0; p < WB_P; p++) begin
        if (wb_ok_s[p]) begin
          data_r[wb_idx_s[p]] <= wb_data[p*DATA_W +: DATA_W];
          done_r[wb_idx_s[p]] <= 1'b1;
        end
      end
      if (ret_rdy) begin
        for (int i = 0; i < RET_W; i++) begin
          if (ret_v[i]) begin
            valid_r[ret_idx_s[i]] <= 1'b0;
            done_r[ret_idx_s[i]]  <= 1'b0;
          end
        end
        head_r <= head_r + TAG_W'(adv_s);
      end
      if (flush_live_s) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (squash_s[e]) begin
            valid_r[e] <= 1'b0;
            done_r[e]  <= 1'b0;
          end
        end
        tail_r <= flush_tag + TAG_W'(1'b1);
      end else if (disp_fire_s) begin
        for (int i = 0; i < DISP_W; i++) begin
          if (disp_lane_s[i]) begin
            valid_r[disp_idx_s[i]] <= 1'b1;
            done_r[disp_idx_s[i]]  <= 1'b0;
            data_r[disp_idx_s[i]]  <= {DATA_W{1'b0}};
            pay_r[disp_idx_s[i]]   <= disp_pay[i*PAY_W +: PAY_W];
          end
        end
        tail_r <= tail_r + TAG_W'(disp_cnt);
      end
    end
  end

endmodule
